// File: rtl/count_snapshot_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : count_snapshot_fifo
//  Description : Captures snapshots of a free-running counter on a strobe and
//                queues them in a small circular FIFO drained through a
//                valid/ready read port. A sticky flag records dropped pushes.
//  Optional    : WRAP_DETECT_EN - when defined, a counter wrap (all-ones to
//                zero) forces a push and each entry carries a wrap tag bit,
//                presented on out_wrap.
//  Ports       : clk        - single clock, rising edge
//                reset      - synchronous active-high reset
//                count      - counter value sampled on a push
//                capture    - push request
//                clear_ovf  - clears the sticky overflow flag
//                out_ready  - consumer accepts the head entry
//                out_valid  - FIFO non-empty
//                out_data   - head entry, 0 when empty
//                level      - occupancy 0..DEPTH
//                overflow   - sticky, set when a push is dropped
//                out_wrap   - wrap tag of head entry (WRAP_DETECT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module count_snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count,
    input  logic                     capture,
    input  logic                     clear_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef WRAP_DETECT_EN
    ,
    output logic                     out_wrap
`endif
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_LW   = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_LW-1:0]  level_q;
    logic [c_LW-1:0]  level_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

`ifdef WRAP_DETECT_EN
    logic [WIDTH-1:0] prev_q;
    logic [DEPTH-1:0] tag_q;
    logic             w_wrap;

    // prev_q resets to 0, so the first sample after reset can never look
    // like an all-ones to zero transition.
    assign w_wrap     = (prev_q == {WIDTH{1'b1}}) && (count == '0);
    assign w_push_req = capture | w_wrap;
`else
    assign w_push_req = capture;
`endif

    assign w_pop  = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = w_push_req & ((level_q != c_FULL) | w_pop);
    assign w_drop = w_push_req & ~w_push;

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LW'(1);
            2'b01:   level_d = level_q - c_LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Setting wins over clearing when both happen in one cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q] <= count;
        end
    end

`ifdef WRAP_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            tag_q  <= '0;
        end else begin
            prev_q <= count;
            if (w_push) begin
                tag_q[wr_ptr_q] <= w_wrap;
            end
        end
    end

    assign out_wrap = out_valid & tag_q[rd_ptr_q];
`endif

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_count_snapshot_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_snapshot_fifo
//  Description : Self-checking bench for count_snapshot_fifo. A queue-based
//                reference model predicts every output after each clock edge;
//                directed sequences are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_snapshot_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count;
    logic             capture;
    logic             clear_ovf;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       level;
    logic             overflow;
`ifdef WRAP_DETECT_EN
    logic             out_wrap;
`endif

    count_snapshot_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .capture   (capture),
        .clear_ovf (clear_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
`ifdef WRAP_DETECT_EN
        ,
        .out_wrap  (out_wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of {tag, data} entries, sticky flag, previous count.
    logic [8:0] m_q[$];
    logic       m_ovf  = 1'b0;
    logic [7:0] m_prev = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic cap, input logic [7:0] cnt,
                                input logic clr, input logic rdy);
        logic wrap;
        logic pop;
        logic drop;
        int   n_before;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_prev = 8'h00;
        end else begin
            wrap = 1'b0;
`ifdef WRAP_DETECT_EN
            wrap = (m_prev == 8'hFF) && (cnt == 8'h00);
`endif
            n_before = m_q.size();
            pop  = (n_before > 0) && rdy;
            drop = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (cap || wrap) begin
                if (n_before < DEPTH || pop) m_q.push_back({wrap, cnt});
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_prev = cnt;
        end
    endtask

    task automatic compare_outputs();
        logic [8:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 9'h000;
        chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
        chk("out_data",  {24'd0, out_data},  {24'd0, head[7:0]});
        chk("level",     {29'd0, level},     m_q.size());
        chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
`ifdef WRAP_DETECT_EN
        chk("out_wrap",  {31'd0, out_wrap},  {31'd0, head[8]});
`endif
    endtask

    // One clock: drive inputs, advance the edge, update model, compare.
    task automatic step(input logic rst, input logic cap, input logic [7:0] cnt,
                        input logic clr, input logic rdy);
        reset     = rst;
        capture   = cap;
        count     = cnt;
        clear_ovf = clr;
        out_ready = rdy;
        @(posedge clk);
        #1;
        model_update(rst, cap, cnt, clr, rdy);
        compare_outputs();
    endtask

    initial begin
        logic [7:0] cnt_r;
        reset = 1'b1; capture = 1'b0; count = '0; clear_ovf = 1'b0; out_ready = 1'b0;

        // Reset then idle.
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {24'd0, out_data},  32'd0);
        chk("rst_level", {29'd0, level},     32'd0);
        chk("rst_ovf",   {31'd0, overflow},  32'd0);
        step(0, 0, 8'h05, 0, 0);

        // Single capture, then pop.
        step(0, 1, 8'h2A, 0, 0);
        chk("single_data",  {24'd0, out_data}, 32'h2A);
        chk("single_level", {29'd0, level},    32'd1);
        step(0, 0, 8'h2B, 0, 1);
        chk("single_pop_valid", {31'd0, out_valid}, 32'd0);

        // Fill and overflow: 0x14 is lost.
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        chk("fill_level", {29'd0, level},    32'd4);
        chk("fill_ovf",   {31'd0, overflow}, 32'd1);

        // Full with simultaneous push and pop.
        step(0, 1, 8'h20, 0, 1);
        chk("full_pp_level", {29'd0, level},    32'd4);
        chk("full_pp_head",  {24'd0, out_data}, 32'h11);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1);
        chk("drained", {29'd0, level}, 32'd0);

        // Clear priority against a dropped push.
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
        step(0, 1, 8'h40, 1, 0);
        chk("clr_vs_drop", {31'd0, overflow}, 32'd1);
        step(0, 0, 8'h41, 1, 0);
        chk("clr_alone", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1);

        // Push and pop with a single entry held.
        step(0, 1, 8'h55, 0, 0);
        step(0, 1, 8'h66, 0, 1);
        chk("one_pp_data", {24'd0, out_data}, 32'h66);
        step(0, 0, 8'h00, 0, 1);

`ifdef WRAP_DETECT_EN
        step(0, 0, 8'hFE, 0, 0);
        step(0, 0, 8'hFF, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("wrap_level", {29'd0, level},    32'd1);
        chk("wrap_data",  {24'd0, out_data}, 32'h00);
        chk("wrap_tag",   {31'd0, out_wrap}, 32'd1);
        step(0, 0, 8'hFE, 0, 1);
        step(1, 0, 8'hFF, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("wrap_after_rst", {29'd0, level}, 32'd0);
`endif

        // Randomized traffic around a mostly free-running counter.
        cnt_r = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99, 0) < 5) cnt_r = 8'($urandom);
            else                           cnt_r = cnt_r + 8'd1;
            step(($urandom_range(199, 0) < 2),
                 ($urandom_range(99, 0) < 40),
                 cnt_r,
                 ($urandom_range(99, 0) < 8),
                 ($urandom_range(99, 0) < 35));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
